// File: rtl/frame_tx_buffer_pkg.sv
// Shared definitions for the frame transmit buffer.
//   WORD_WIDTH_DEFAULT      : default bits per word (matches sendFrame)
//   WORDS_PER_FRAME_DEFAULT : default words per frame
//   txState_t               : read-side launch FSM encoding (idle=0, start=1, busy=2)
package frame_tx_buffer_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT      = 8;
  localparam int unsigned WORDS_PER_FRAME_DEFAULT = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2
  } txState_t;

endpackage

// File: rtl/frame_slot_ram.sv
// Frame slot storage: (1 << ADDR_WIDTH) words of WORD_WIDTH bits.
// Synchronous write, asynchronous (combinational) read. Contents are not reset.
//   clock       : write clock, rising edge
//   writeEnable : store writeData at writeAddr on the next rising edge
//   writeAddr   : write address {slot, word}
//   writeData   : word to store
//   readAddr    : read address {slot, word}
//   readData    : word at readAddr, combinational
module frame_slot_ram
  import frame_tx_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [WORD_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [WORD_WIDTH-1:0] readData
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem[writeAddr] <= writeData;
    end
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/frame_tx_buffer.sv
// Frame transmit buffer feeding sendFrame.
// Packs words from a valid/ready stream into frames of WORDS_PER_FRAME words,
// holds up to FRAME_DEPTH committed frames, and launches sendFrame with a
// one-cycle start pulse per frame. sendFrame reads the head frame through
// frameIndex/frameData and releases it with senderReadyAtNext.
//   clock             : sole clock, rising edge
//   resetN            : asynchronous active-low reset
//   inValid/inReady   : input word handshake
//   inData            : input word; first accepted word of a frame is index 0
//   start             : one-cycle launch pulse to sendFrame
//   frameIndex        : word index requested by sendFrame
//   frameData         : head-frame word at frameIndex, combinational
//   senderReadyAtNext : sendFrame done with the head frame (honoured only when busy past start)
//   framesStored      : committed frames not yet fully sent, head included
//   busy              : a frame is in flight
module frame_tx_buffer
  import frame_tx_buffer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = WORD_WIDTH_DEFAULT,
  parameter int unsigned WORDS_PER_FRAME = WORDS_PER_FRAME_DEFAULT,
  parameter int unsigned INDEX_WIDTH     = $clog2(WORDS_PER_FRAME),
  parameter int unsigned FRAME_DEPTH     = 4
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [WORD_WIDTH-1:0]          inData,
  output logic                           start,
  input  logic [INDEX_WIDTH-1:0]         frameIndex,
  output logic [WORD_WIDTH-1:0]          frameData,
  input  logic                           senderReadyAtNext,
  output logic [$clog2(FRAME_DEPTH):0]   framesStored,
  output logic                           busy
);

  localparam int unsigned SLOT_WIDTH  = $clog2(FRAME_DEPTH);
  localparam int unsigned COUNT_WIDTH = SLOT_WIDTH + 1;
  localparam int unsigned ADDR_WIDTH  = SLOT_WIDTH + INDEX_WIDTH;

  localparam logic [INDEX_WIDTH-1:0] LAST_WORD  = INDEX_WIDTH'(WORDS_PER_FRAME - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FRAME_DEPTH);

  txState_t               state;
  logic [SLOT_WIDTH-1:0]  wrSlot;
  logic [SLOT_WIDTH-1:0]  rdSlot;
  logic [INDEX_WIDTH-1:0] wrWord;

  logic accept;
  logic commit;
  logic pop;

  // Based on the pre-pop count, so a full buffer never accepts even while popping.
  assign inReady = (framesStored < FULL_COUNT);
  assign accept  = inValid && inReady;
  assign commit  = accept && (wrWord == LAST_WORD);
  assign pop     = (state == StBusy) && senderReadyAtNext;

  // Write pointer: word and slot counters wrap naturally (both sizes are powers of two).
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrWord <= '0;
      wrSlot <= '0;
    end else if (accept) begin
      wrWord <= wrWord + 1'b1;
      if (commit) begin
        wrSlot <= wrSlot + 1'b1;
      end
    end
  end

  // Committed-frame count; a simultaneous commit and pop cancel out.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      framesStored <= '0;
    end else begin
      unique case ({commit, pop})
        2'b10:   framesStored <= framesStored + 1'b1;
        2'b01:   framesStored <= framesStored - 1'b1;
        default: framesStored <= framesStored;
      endcase
    end
  end

  // Launch FSM with registered start/busy; the head pointer advances on pop.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= StIdle;
      start  <= 1'b0;
      busy   <= 1'b0;
      rdSlot <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (framesStored != '0) begin
            state <= StStart;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          state <= StBusy;
          start <= 1'b0;
        end
        StBusy: begin
          if (senderReadyAtNext) begin
            state  <= StIdle;
            busy   <= 1'b0;
            rdSlot <= rdSlot + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          start <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  frame_slot_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) slotRam (
    .clock       (clock),
    .writeEnable (accept),
    .writeAddr   ({wrSlot, wrWord}),
    .writeData   (inData),
    .readAddr    ({rdSlot, frameIndex}),
    .readData    (frameData)
  );

endmodule

// File: tb/tb_frame_tx_buffer.sv
// Self-checking bench for frame_tx_buffer (default parameters: 8-bit words,
// 2 words per frame, 4 frame slots). A queue-based model tracks committed
// frames and the launch timing; a negedge process compares every cycle.
module tb_frame_tx_buffer;
  import frame_tx_buffer_pkg::*;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [7:0] inData = '0;
  logic       start;
  logic [0:0] frameIndex = '0;
  logic [7:0] frameData;
  logic       senderReadyAtNext = 1'b0;
  logic [2:0] framesStored;
  logic       busy;

  int total = 0;
  int bad   = 0;

  frame_tx_buffer dut (
    .clock             (clock),
    .resetN            (resetN),
    .inValid           (inValid),
    .inReady           (inReady),
    .inData            (inData),
    .start             (start),
    .frameIndex        (frameIndex),
    .frameData         (frameData),
    .senderReadyAtNext (senderReadyAtNext),
    .framesStored      (framesStored),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of committed frames {word1, word0}, a partial word, and the
  // number of cycles since the current launch began (-1 when nothing in flight).
  logic [15:0] fq[$];
  logic [7:0]  part;
  int          partCnt = 0;
  int          sinceLaunch = -1;
  int          preSize;
  bit          mAcc;
  bit          mPop;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fq.delete();
      partCnt     = 0;
      sinceLaunch = -1;
    end else begin
      preSize = fq.size();
      mAcc    = inValid && (preSize < 4);
      mPop    = (sinceLaunch >= 1) && senderReadyAtNext;
      if (mAcc) begin
        if (partCnt == 0) begin
          part    = inData;
          partCnt = 1;
        end else begin
          fq.push_back({inData, part});
          partCnt = 0;
        end
      end
      if (mPop) void'(fq.pop_front());
      if (sinceLaunch < 0)  sinceLaunch = (preSize != 0) ? 0 : -1;
      else if (mPop)        sinceLaunch = -1;
      else                  sinceLaunch++;
    end
  end

  always @(negedge clock) begin
    if (resetN) begin
      check("inReady", inReady, fq.size() < 4);
      check("start", start, sinceLaunch == 0);
      check("busy", busy, sinceLaunch >= 0);
      check("framesStored", framesStored, fq.size());
      if (fq.size() != 0)
        check("frameData", frameData, frameIndex[0] ? fq[0][15:8] : fq[0][7:0]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    inValid = 1'b0;
    senderReadyAtNext = 1'b0;
    resetN = 1'b0;
    step();
    resetN = 1'b1;
  endtask

  logic [15:0] rxWord;
  logic [15:0] caps[$];
  int          times[$];
  int          wIdx;
  int          starts;
  bit          acc;
  bit          rdy;

  initial begin
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;

    // Basic frame: 0x76, 0xA5.
    doReset();
    check("rst_stored", framesStored, 0);
    check("rst_ready", inReady, 1);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    inValid = 1'b1; inData = 8'h76; step();
    check("t1_stored_w0", framesStored, 0);
    inData = 8'hA5; step();
    inValid = 1'b0;
    check("t1_stored_w1", framesStored, 1);
    check("t1_nostart", start, 0);
    step();
    check("t1_start", start, 1);
    check("t1_busy", busy, 1);
    frameIndex = 1'b0; #1 rxWord[15:8] = frameData;
    check("t1_data0", frameData, 8'h76);
    frameIndex = 1'b1; #1 rxWord[7:0] = frameData;
    check("t1_data1", frameData, 8'hA5);
    check("t1_rx", rxWord, 16'b0111011010100101);
    step();
    check("t1_start_once", start, 0);
    senderReadyAtNext = 1'b1; step(); senderReadyAtNext = 1'b0;
    check("t1_pop_busy", busy, 0);
    check("t1_pop_stored", framesStored, 0);

    // Back-to-back fill with a stalled sender: words 8 and 9 are held off.
    doReset();
    for (int i = 0; i < 10; i++) begin
      inValid = 1'b1; inData = 8'(i);
      rdy = inReady;
      check($sformatf("t2_ready%0d", i), rdy, i < 8);
      step();
    end
    inValid = 1'b0;
    check("t2_stored", framesStored, 4);
    check("t2_busy", busy, 1);
    check("t2_ready_low", inReady, 0);

    // Pop frame (0,1), then commit and pop in the same cycle.
    senderReadyAtNext = 1'b1; step(); senderReadyAtNext = 1'b0;
    check("t3_stored_after_pop", framesStored, 3);
    inValid = 1'b1; inData = 8'h20; step(); inValid = 1'b0;
    check("t3_start", start, 1);
    step();
    check("t3_busy", busy, 1);
    frameIndex = 1'b0; #1;
    check("t3_head0", frameData, 8'h02);
    inValid = 1'b1; inData = 8'h21; senderReadyAtNext = 1'b1;
    step();
    inValid = 1'b0; senderReadyAtNext = 1'b0;
    check("t3_commit_pop", framesStored, 3);
    step();
    check("t3_start2", start, 1);
    frameIndex = 1'b0; #1 check("t3_next0", frameData, 8'h04);
    frameIndex = 1'b1; #1 check("t3_next1", frameData, 8'h05);

    // Reset mid-BUSY with a partial frame pending.
    step();
    inValid = 1'b1; inData = 8'h30; step(); inValid = 1'b0;
    resetN = 1'b0; #1;
    check("t4_start", start, 0);
    check("t4_busy", busy, 0);
    check("t4_stored", framesStored, 0);
    check("t4_ready", inReady, 1);
    step(); resetN = 1'b1;
    inValid = 1'b1; inData = 8'h3C; step();
    inData = 8'h3D; step(); inValid = 1'b0;
    step();
    check("t4_start_fresh", start, 1);
    frameIndex = 1'b0; #1 check("t4_fresh0", frameData, 8'h3C);
    frameIndex = 1'b1; #1 check("t4_fresh1", frameData, 8'h3D);
    senderReadyAtNext = 1'b1; step(); senderReadyAtNext = 1'b0;

    // Nine frames 0x00..0x11 through the slot wrap, random pacing.
    doReset();
    wIdx = 0; starts = 0; caps.delete();
    for (int c = 0; c < 800 && !(starts == 9 && wIdx == 18); c++) begin
      inValid = (wIdx < 18) ? 1'($urandom_range(1)) : 1'b0;
      inData = 8'(wIdx);
      senderReadyAtNext = 1'($urandom_range(1));
      frameIndex = 1'($urandom_range(1));
      acc = inValid && inReady;
      step();
      if (acc) wIdx++;
      if (start) begin
        starts++;
        frameIndex = 1'b0; #1 rxWord[7:0] = frameData;
        frameIndex = 1'b1; #1 rxWord[15:8] = frameData;
        caps.push_back(rxWord);
      end
    end
    inValid = 1'b0;
    senderReadyAtNext = 1'b1; repeat (3) step(); senderReadyAtNext = 1'b0;
    check("t5_starts", starts, 9);
    check("t5_words", wIdx, 18);
    check("t5_drained", framesStored, 0);
    for (int k = 0; k < caps.size(); k++)
      check($sformatf("t5_frame%0d", k), caps[k], {8'(2 * k + 1), 8'(2 * k)});

    // Continuous senderReadyAtNext: starts spaced by 3 cycles.
    doReset();
    times.delete();
    senderReadyAtNext = 1'b1;
    for (int c = 0; c < 24; c++) begin
      inValid = (c < 4);
      inData = 8'(8'h50 + c);
      step();
      if (start) times.push_back(c);
    end
    inValid = 1'b0; senderReadyAtNext = 1'b0;
    check("t6_count", times.size(), 2);
    if (times.size() == 2) check("t6_spacing", times[1] - times[0], 3);
    check("t6_stored", framesStored, 0);

    // Random traffic with occasional resets.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(399) == 0) doReset();
      inValid = 1'($urandom_range(1));
      inData = 8'($urandom);
      frameIndex = 1'($urandom_range(1));
      senderReadyAtNext = ($urandom_range(2) == 0);
      step();
    end
    inValid = 1'b0; senderReadyAtNext = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
